// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: holds ALU operands for a per-opcode settle interval, then captures OUT/ZERO.
// Define ALU_EXEC_FAST_LOGIC_EN to give shift/and/or/nor opcodes (0x4-0x8) a one-cycle settle.
module alu_exec_sequencer #(
   parameter int DATA_WIDTH        = 32,
   parameter int SETTLE_CYCLES     = 4,
   parameter int MUL_SETTLE_CYCLES = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic [DATA_WIDTH-1:0] REQ_OP1,
   input  logic [DATA_WIDTH-1:0] REQ_OP2,
   input  logic [5:0]            REQ_OPRN,
   output logic [DATA_WIDTH-1:0] ALU_OP1,
   output logic [DATA_WIDTH-1:0] ALU_OP2,
   output logic [5:0]            ALU_OPRN,
   input  logic [DATA_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_ZERO,
   output logic                  RES_VALID,
   input  logic                  RES_READY,
   output logic [DATA_WIDTH-1:0] RES_DATA,
   output logic                  RES_ZERO,
   output logic                  RES_ILLEGAL,
   output logic                  BUSY
);
   localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2;
   localparam logic [3:0] SET_M1 = 4'(SETTLE_CYCLES - 1), MUL_M1 = 4'(MUL_SETTLE_CYCLES - 1);
   logic [1:0] state;
   logic [3:0] cnt, load_cnt;
   logic       accept, req_illegal, alu_illegal, fast;
`ifdef ALU_EXEC_FAST_LOGIC_EN
   assign fast = REQ_OPRN >= 6'h4 && REQ_OPRN <= 6'h8;
`else
   assign fast = 1'b0;
`endif
   assign REQ_READY   = state == IDLE || (state == DONE && RES_READY);
   assign accept      = REQ_VALID && REQ_READY;
   assign req_illegal = REQ_OPRN == 6'h0 || REQ_OPRN > 6'h9;
   assign alu_illegal = ALU_OPRN == 6'h0 || ALU_OPRN > 6'h9;
   assign load_cnt    = (req_illegal || fast) ? 4'd0 : REQ_OPRN == 6'h3 ? MUL_M1 : SET_M1;
   assign RES_VALID   = state == DONE;
   assign BUSY        = state == SETTLE;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         ALU_OP1     <= '0;
         ALU_OP2     <= '0;
         ALU_OPRN    <= '0;
         RES_DATA    <= '0;
         RES_ZERO    <= 1'b0;
         RES_ILLEGAL <= 1'b0;
      end else if (accept) begin
         ALU_OP1  <= REQ_OP1;
         ALU_OP2  <= REQ_OP2;
         ALU_OPRN <= REQ_OPRN;
         cnt      <= load_cnt;
         state    <= SETTLE;
      end else if (state == SETTLE) begin
         if (cnt == 4'd0) begin
            RES_DATA    <= ALU_OUT;
            RES_ZERO    <= ALU_ZERO;
            RES_ILLEGAL <= alu_illegal;
            state       <= DONE;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end else if (state == DONE && RES_READY) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: directed and random ops against a behavioural ALU and latency model.
module tb_alu_exec_sequencer;
   localparam int W = 32, SC = 4, MC = 8;
   logic         CLK = 1'b0, RST = 1'b0;
   logic         REQ_VALID = 1'b0, REQ_READY, RES_READY = 1'b0;
   logic [W-1:0] REQ_OP1 = '0, REQ_OP2 = '0, ALU_OP1, ALU_OP2, alu_out, RES_DATA;
   logic [5:0]   REQ_OPRN = '0, ALU_OPRN;
   logic         alu_zero, RES_VALID, RES_ZERO, RES_ILLEGAL, BUSY;
   int           checks = 0, errors = 0;

   alu_exec_sequencer #(.DATA_WIDTH(W), .SETTLE_CYCLES(SC), .MUL_SETTLE_CYCLES(MC)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_OP1(REQ_OP1), .REQ_OP2(REQ_OP2), .REQ_OPRN(REQ_OPRN),
      .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
      .ALU_OUT(alu_out), .ALU_ZERO(alu_zero), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .RES_ZERO(RES_ZERO), .RES_ILLEGAL(RES_ILLEGAL), .BUSY(BUSY));

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b, input logic [5:0] op);
      case (op)
         6'h1: return a + b;
         6'h2: return a - b;
         6'h3: return a * b;
         6'h4: return a << b[4:0];
         6'h5: return a >> b[4:0];
         6'h6: return a & b;
         6'h7: return a | b;
         6'h8: return ~(a | b);
         6'h9: return (a < b) ? 1 : 0;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int lat(input logic [5:0] op);
      if (op == 6'h3) return MC;
      if (op == 6'h0 || op > 6'h9) return 1;
`ifdef ALU_EXEC_FAST_LOGIC_EN
      if (op >= 6'h4 && op <= 6'h8) return 1;
`endif
      return SC;
   endfunction

   always_comb begin
      alu_out  = alu_f(ALU_OP1, ALU_OP2, ALU_OPRN);
      alu_zero = alu_out == '0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one op from IDLE or DONE (back-to-back), checks latency, busy time, result and hold behaviour.
   task automatic run_op(input logic [W-1:0] a, b, input logic [5:0] op, input int hold, input bit chain);
      logic [W-1:0] exp_d;
      int s, j, busy_n;
      exp_d = alu_f(a, b, op);
      s = lat(op);
      REQ_VALID = 1'b1; REQ_OP1 = a; REQ_OP2 = b; REQ_OPRN = op; RES_READY = 1'b1;
      #1 chk("req_ready_accept", 64'(REQ_READY), 64'd1);
      @(negedge CLK);
      REQ_VALID = 1'b0; RES_READY = 1'b0;
      chk("alu_operands", {ALU_OP1, ALU_OP2}, {a, b});
      j = 0; busy_n = 0;
      while (!RES_VALID && j < 40) begin
         busy_n += int'(BUSY);
         @(negedge CLK);
         j++;
      end
      chk("latency", 64'(j), 64'(s));
      chk("busy_cycles", 64'(busy_n), 64'(s));
      chk("res_data", 64'(RES_DATA), 64'(exp_d));
      chk("res_flags", {62'd0, RES_ZERO, RES_ILLEGAL}, {62'd0, exp_d == '0, op == 6'h0 || op > 6'h9});
      for (int k = 0; k < hold; k++) begin
         REQ_VALID = 1'b1; REQ_OP1 = $urandom; REQ_OPRN = 6'h1;
         @(negedge CLK);
         chk("hold_stable", {RES_VALID, REQ_READY, RES_DATA, ALU_OP1, ALU_OPRN},
             {1'b1, 1'b0, exp_d, a, op});
      end
      REQ_VALID = 1'b0;
      if (!chain) begin
         RES_READY = 1'b1;
         @(negedge CLK);
         RES_READY = 1'b0;
         chk("consumed_idle", {62'd0, RES_VALID, BUSY}, 64'd0);
      end
   endtask

   initial begin
      bit rv_seen;
      logic [5:0] op;
      REQ_OP1 = $urandom; REQ_OP2 = $urandom; REQ_OPRN = 6'h3;
      #3;
      chk("reset_outputs", {ALU_OP1, ALU_OP2, ALU_OPRN, RES_DATA, RES_ZERO, RES_ILLEGAL, RES_VALID, BUSY},
          '0);
      chk("reset_req_ready", 64'(REQ_READY), 64'd1);
      @(negedge CLK); RST = 1'b1;
      run_op(32'h5, 32'h3, 6'h1, 0, 1'b0);
      run_op(32'h7, 32'h7, 6'h2, 10, 1'b0);
      run_op(32'h10, 32'h10, 6'h3, 0, 1'b0);
      run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 6'h6, 0, 1'b0);
      run_op(32'h1234, 32'h1234, 6'h0F, 1, 1'b0);
      run_op(32'h9, 32'h4, 6'h1, 0, 1'b0);
      run_op(32'h3, 32'h5, 6'h3, 1, 1'b1);
      run_op(32'hA, 32'h2, 6'h2, 0, 1'b1);
      run_op(32'h8, 32'h1, 6'h5, 0, 1'b0);
      run_op(32'h0, 32'h0, 6'h3F, 0, 1'b0);
      // Mid-settle reset of a multiply must discard the op.
      REQ_VALID = 1'b1; REQ_OP1 = 32'h20; REQ_OP2 = 32'h30; REQ_OPRN = 6'h3;
      @(negedge CLK); REQ_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1 chk("midreset_outputs",
             {ALU_OP1, ALU_OP2, ALU_OPRN, RES_DATA, RES_ZERO, RES_ILLEGAL, RES_VALID, BUSY}, '0);
      chk("midreset_req_ready", 64'(REQ_READY), 64'd1);
      @(negedge CLK); RST = 1'b1;
      rv_seen = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         rv_seen |= RES_VALID | BUSY;
      end
      chk("no_result_after_reset", 64'(rv_seen), 64'd0);
      run_op(32'h6, 32'h7, 6'h3, 0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(10, 63)) : 6'($urandom_range(0, 9));
         run_op($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, op,
                $urandom_range(0, 3), i != 29 && $urandom_range(0, 1) == 1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
